demux_stream_1_n: RTL
=====================

Name: demux_stream_1_n

Overview:
- Parametrised, registered 1:N demultiplexer with valid/ready handshake on the input and on every output.
- Successor to the combinational 1:8 demux. Adds a generic output count, a registered hold stage, per-output back-pressure, a broadcast mode and an out-of-range drop counter.
- Sits between a single producer stream and N consumer channels in the datapath.

Parameters:
- DATA_W, 8, width of the data word.
- N_OUT, 8, number of output channels (2..32).
- SEL_W, $clog2(N_OUT), width of the select field. Derived; do not override.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  DATA_W  input word.
- s_sel  input  SEL_W  destination channel index.
- s_bcast  input  1  1 = deliver to all N_OUT channels; s_sel is ignored.
- m_valid  output  N_OUT  per-channel valid; bit i belongs to channel i.
- m_ready  input  N_OUT  per-channel ready.
- m_data  output  DATA_W  held word, shared by all channels.
- busy  output  1  at least one delivery is pending.
- drop_cnt  output  CNT_W  number of words dropped for an out-of-range select; saturates.

Behaviour:
- Reset (rst=1 at a clk edge): pend=0, m_valid=0, m_data=0, busy=0, drop_cnt=0.
  - s_ready is 0 while rst is high.
  - A word held or in flight when reset hits is discarded; it is never partially delivered afterwards.
- Internal state:
  - pend[N_OUT]: mask of channels that still owe a handshake.
  - data_q: the held word.
- States: IDLE (pend==0) and HOLD (pend!=0). busy = (pend != 0).
- Outputs in each state:
  - m_valid = pend.
  - m_data = data_q.
  - m_data holds its value while in HOLD. In IDLE it keeps its last value.
- Channel handshake:
  - Channel i completes when m_valid[i] & m_ready[i].
  - On completion, bit i is cleared at the next edge.
  - Channels complete independently and in any order.
  - m_valid[i] never drops before it is accepted.
- s_ready = ~rst & ((pend & ~m_ready) == 0).
  - This means the block is empty, or every remaining pending channel is accepting this cycle.
  - This gives back-to-back throughput of one word per cycle. It is a combinational path from m_ready to s_ready, by design.
- Input acceptance (s_valid & s_ready): at the next edge,
  - data_q <= s_data;
  - pend <= s_bcast ? all ones : onehot(s_sel).
  - Any pending bits that completed in the same cycle are superseded by the new mask.
- Latency: a word accepted at edge k appears on m_valid/m_data from cycle k+1. A downstream that is always ready gives 1-cycle latency.
- Out-of-range select (s_bcast=0 and s_sel >= N_OUT; only possible when N_OUT is not a power of 2):
  - The word is accepted and discarded.
  - pend <= 0 and data_q is unchanged.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- Broadcast: all N_OUT bits are set. The block stays in HOLD until the slowest channel completes.
- Simultaneous acceptance and final completion in one cycle:
  - The old word's last handshakes complete.
  - The new mask loads.
  - No bubble cycle.
- Inputs s_data, s_sel and s_bcast are don't-care when s_valid=0.
- A producer may drop s_valid without a handshake.

Decomposition:
- Shared package demux_pkg holds:
  - the function onehot_dec(sel, n) returning an N_OUT-bit mask;
  - the constant DEMUX_MAX_OUT = 32.
- One sub-module, demux_sel_decode: combinational SEL_W -> N_OUT one-hot decoder with an in_range flag.
  - It generalises the existing 1:8 decoder.
  - It is instantiated once, for the load mask and the drop detection.

Test Plan:
1. Reset, then with N_OUT=8 and all m_ready=1, send s_data=0xA5 with s_sel=3.
   - Next cycle: m_valid=0x08 and m_data=0xA5.
   - The cycle after: m_valid=0x00.
   - s_ready stays 1 throughout.
2. Back-to-back stream with all m_ready=1, sel=0,1,...,7 on consecutive cycles.
   - m_valid walks 0x01,0x02,...,0x80 one cycle behind the input.
   - s_ready is never 0.
3. Broadcast 0x3C with m_ready released one bit per cycle from bit 0 to bit 7.
   - m_valid goes 0xFF,0xFE,...,0x80,0x00.
   - s_ready=0 until the cycle in which m_ready[7] goes high.
   - m_data=0x3C throughout.
4. Back-pressure: send sel=5 with m_ready[5]=0 for 4 cycles, while s_valid stays high with the next word (data 0x11).
   - m_valid=0x20 and m_data holds.
   - The second word is accepted in the same cycle m_ready[5] rises.
   - Then m_valid=onehot of the second word's sel and m_data=0x11.
5. Parametrise N_OUT=6 and send sel=6 and sel=7.
   - Both are accepted and drop_cnt reaches 2.
   - m_valid stays 0 and m_data is unchanged.
   - Force 300 drops with CNT_W=8: drop_cnt saturates at 255.
6. Assert rst while in HOLD with m_valid=0x04.
   - At the next edge: m_valid=0, busy=0, drop_cnt=0.
   - s_ready=0 during reset and 1 in the first cycle after it.
   - The discarded word never reappears.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:N stream demultiplexer family.
// Holds the channel-count ceiling and the select-to-mask helper.
package demux_pkg;

  localparam int DEMUX_MAX_OUT = 32;

  // Bits at or above n stay clear, so an out-of-range select yields an all-zero mask.
  function automatic logic [DEMUX_MAX_OUT-1:0] onehot_dec(input int sel, input int n);
    logic [DEMUX_MAX_OUT-1:0] mask;
    mask = '0;
    if (sel >= 0 && sel < n && sel < DEMUX_MAX_OUT) begin
      mask = DEMUX_MAX_OUT'(1) << sel;
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux_sel_decode.sv
// Combinational select decoder: SEL_W index to N_OUT-bit one-hot mask,
// plus a flag telling whether the index names a real channel.
module demux_sel_decode
  import demux_pkg::*;
#(
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             in_range
);

  logic [DEMUX_MAX_OUT-1:0] full_mask;

  assign full_mask = onehot_dec(int'(sel), N_OUT);
  assign onehot    = full_mask[N_OUT-1:0];
  assign in_range  = |full_mask;

endmodule

// File: rtl/demux_stream_1_n.sv
// Registered 1:N stream demultiplexer with per-channel back-pressure,
// broadcast delivery and a saturating counter of out-of-range drops.
module demux_stream_1_n
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_bcast,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [N_OUT-1:0]  pend_reg;
  logic [N_OUT-1:0]  pend_next;
  logic [N_OUT-1:0]  dec_mask;
  logic [N_OUT-1:0]  load_mask;
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  drop_cnt_reg;
  logic              in_range;
  logic              accept;
  logic              drop;

  demux_sel_decode #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_sel_decode (
    .sel      (s_sel),
    .onehot   (dec_mask),
    .in_range (in_range)
  );

  // Ready as soon as every still-pending channel is handshaking this cycle,
  // which keeps a fully ready downstream at one word per clock.
  assign s_ready   = ~rst & ((pend_reg & ~m_ready) == '0);
  assign accept    = s_valid & s_ready;
  assign drop      = accept & ~s_bcast & ~in_range;
  assign load_mask = s_bcast ? '1 : dec_mask;

  // A newly accepted word supersedes whatever completed in the same cycle.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pend
      assign pend_next[gi] = accept ? load_mask[gi] : (pend_reg[gi] & ~m_ready[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg     <= '0;
      data_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (accept && (s_bcast || in_range)) begin
        data_reg <= s_data;
      end
      if (drop && drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign m_valid  = pend_reg;
  assign m_data   = data_reg;
  assign busy     = |pend_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
